// File: rtl/filter_capture.sv
// filter_capture: Avalon-ST sink terminating the band-pass FIR output.
// Each accepted result is rounded half-up, shifted right by SHIFT and
// narrowed to OUT_W bits. It is then written to a sample RAM at wr_count,
// and the RAM is read back through a registered host port.
// Optional feature: define FILTER_CAPTURE_SAT_EN to saturate out-of-range
// samples and raise sat_flag; otherwise the narrowed value wraps.
module filter_capture #(
  parameter int DATA_W = 93,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 24,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic [ADDR_W:0]   i_count,
  input  logic [DATA_W-1:0] i_ast_sink_data,
  input  logic              i_ast_sink_valid,
  input  logic [1:0]        i_ast_sink_error,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_en,
  output logic [OUT_W-1:0]  o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_wr_count,
  output logic              o_err_flag,
  output logic              o_sat_flag
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int                      LP_HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [DATA_W:0]  LP_HALF     = (SHIFT > 0) ?
                                        ({{DATA_W{1'b0}}, 1'b1} << LP_HALF_POS) : '0;
  localparam logic [ADDR_W:0]         LP_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]         LP_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]         LP_ZERO     = '0;

  state_t             r_state;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W:0]    r_acc;
  logic [ADDR_W:0]    r_wr_count;
  logic               r_busy;
  logic               r_done;
  logic               r_err_flag;
  logic               r_sat_flag;
  logic               r_rnd_valid;
  logic [OUT_W-1:0]   r_rnd_data;
  logic               r_rnd_err;
  logic               r_rnd_sat;
  logic [OUT_W-1:0]   r_rd_data;
  logic [OUT_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic signed [DATA_W:0] w_ext;
  logic signed [DATA_W:0] w_sum;
  logic [OUT_W-1:0]       w_rnd;
  logic                   w_sat;
  logic                   w_accept;
  logic [ADDR_W:0]        w_count_clamped;

  // Sign-extend by one bit so adding the rounding constant cannot overflow.
  assign w_ext = {i_ast_sink_data[DATA_W-1], i_ast_sink_data};
  assign w_sum = w_ext + LP_HALF;

`ifdef FILTER_CAPTURE_SAT_EN
  logic signed [DATA_W:0]  w_shift;
  logic [DATA_W-OUT_W+1:0] w_hi;
  logic                    w_fits;

  // The value fits OUT_W signed bits only when all bits above the
  // narrowed sign bit equal it.
  assign w_shift = w_sum >>> SHIFT;
  assign w_hi    = w_shift[DATA_W:OUT_W-1];
  assign w_fits  = (&w_hi) | ~(|w_hi);
  assign w_sat   = ~w_fits;
  assign w_rnd   = w_fits ? w_shift[OUT_W-1:0] :
                   (w_shift[DATA_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}});
`else
  // Wrap mode keeps only the low OUT_W bits of the rounded value.
  assign w_rnd = OUT_W'(w_sum >>> SHIFT);
  assign w_sat = 1'b0;
`endif

  // A beat counts only while capturing and the programmed total is not yet reached.
  assign w_accept        = (r_state == S_CAPTURE) && i_ast_sink_valid && (r_acc != r_count);
  assign w_count_clamped = (i_count > LP_DEPTH) ? LP_DEPTH : i_count;

  // Control FSM together with the round stage, write counter and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_wr_count  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_flag  <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_rnd_data  <= '0;
      r_rnd_err   <= 1'b0;
      r_rnd_sat   <= 1'b0;
    end else begin
      r_rnd_valid <= w_accept;
      if (w_accept) begin
        r_rnd_data <= w_rnd;
        r_rnd_err  <= |i_ast_sink_error;
        r_rnd_sat  <= w_sat;
        r_acc      <= r_acc + LP_ONE;
      end
      if (r_rnd_valid) begin
        r_wr_count <= r_wr_count + LP_ONE;
        r_err_flag <= r_err_flag | r_rnd_err;
        r_sat_flag <= r_sat_flag | r_rnd_sat;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            r_count    <= w_count_clamped;
            r_acc      <= '0;
            r_wr_count <= '0;
            r_err_flag <= 1'b0;
            r_sat_flag <= 1'b0;
            if (w_count_clamped == LP_ZERO) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CAPTURE;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        S_CAPTURE: begin
          // The last beat is in the round stage now; it is written this edge.
          if (r_acc == r_count) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sample RAM write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (r_rnd_valid && !i_rst) begin
      r_mem[r_wr_count[ADDR_W-1:0]] <= r_rnd_data;
    end
  end

  // Registered host read; a same-address write in this cycle returns old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_wr_count = r_wr_count;
  assign o_err_flag = r_err_flag;
  assign o_sat_flag = r_sat_flag;

endmodule

// File: tb/tb_filter_capture.sv
// Testbench for filter_capture: directed vectors with literal expectations,
// plus a cycle-based behavioural model compared on every falling edge.
// Honours FILTER_CAPTURE_SAT_EN the same way the design does.
module tb_filter_capture;

  localparam int DATA_W = 93;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 24;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              arm;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] ast_data;
  logic              valid;
  logic [1:0]        err;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [OUT_W-1:0]  o_rd_data;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_wr_count;
  logic              o_err_flag;
  logic              o_sat_flag;

  longint drv_d;
  int     n_checks;
  int     n_pass;

  assign ast_data = {{(DATA_W-64){drv_d[63]}}, drv_d};

  filter_capture #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_arm           (arm),
    .i_count         (count),
    .i_ast_sink_data (ast_data),
    .i_ast_sink_valid(valid),
    .i_ast_sink_error(err),
    .i_rd_addr       (rd_addr),
    .i_rd_en         (rd_en),
    .o_rd_data       (o_rd_data),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_wr_count      (o_wr_count),
    .o_err_flag      (o_err_flag),
    .o_sat_flag      (o_sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic longint sh(input longint v);
    return v * 64'sd16777216;
  endfunction

  // Spec-level sample conversion: floor((d + 2^(SHIFT-1)) / 2^SHIFT), then narrow.
  function automatic longint model_store(input longint d, output bit sat);
    longint n, q, div;
    div = longint'(1) << SHIFT;
    n   = d + (div / 2);
    q   = n / div;
    if (n < 0 && q * div != n) q = q - 1;
    sat = 1'b0;
`ifdef FILTER_CAPTURE_SAT_EN
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
`else
    q = q % 65536;
    if (q < 0) q = q + 65536;
    if (q >= 32768) q = q - 65536;
`endif
    return q;
  endfunction

  // ---------------- behavioural model ----------------
  longint m_mem [0:DEPTH-1];
  bit     m_known [0:DEPTH-1];
  bit     m_started;
  bit     m_active, m_done, m_err, m_sat;
  int     m_wr, m_acc, m_target, m_cyc, m_finish;
  bit     m_pend, m_pend_err, m_pend_sat;
  longint m_pend_val;
  longint m_rd;
  bit     m_rd_known;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_started = 0; m_active = 0; m_done = 0; m_err = 0; m_sat = 0;
    m_wr = 0; m_acc = 0; m_target = 0; m_cyc = 0; m_finish = -1;
    m_pend = 0; m_rd = 0; m_rd_known = 1;
  end

  always @(posedge clk) begin : model
    bit was_active;
    bit s;
    m_started = 1'b1;
    if (rst) begin
      m_active = 0; m_done = 0; m_wr = 0; m_err = 0; m_sat = 0;
      m_pend = 0; m_rd = 0; m_rd_known = 1;
    end else begin
      m_cyc++;
      was_active = m_active;
      if (rd_en) begin
        m_rd_known = m_known[rd_addr];
        m_rd       = m_mem[rd_addr];
      end
      if (m_pend) begin
        m_mem[m_wr]   = m_pend_val;
        m_known[m_wr] = 1'b1;
        m_wr++;
        m_err  = m_err | m_pend_err;
        m_sat  = m_sat | m_pend_sat;
        m_pend = 0;
      end
      if (was_active && valid && m_acc < m_target) begin
        m_pend_val = model_store(drv_d, s);
        m_pend_sat = s;
        m_pend_err = (err != 2'b00);
        m_pend     = 1;
        m_acc++;
        if (m_acc == m_target) m_finish = m_cyc + 2;
      end
      if (was_active && m_acc == m_target && m_cyc == m_finish) begin
        m_active = 0;
        m_done   = 1;
      end
      if (!was_active && arm) begin
        m_target = (int'(count) > DEPTH) ? DEPTH : int'(count);
        m_acc = 0; m_wr = 0; m_err = 0; m_sat = 0;
        if (m_target == 0) begin m_active = 0; m_done = 1; end
        else begin m_active = 1; m_done = 0; end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("m_busy", o_busy, m_active);
      chk("m_done", o_done, m_done);
      chk("m_wr_count", o_wr_count, m_wr);
      chk("m_err_flag", o_err_flag, m_err);
      chk("m_sat_flag", o_sat_flag, m_sat);
      if (m_rd_known) chk("m_rd_data", $signed(o_rd_data), m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic beat(input longint d, input logic [1:0] e);
    valid = 1'b1; drv_d = d; err = e;
    step();
    valid = 1'b0; drv_d = 0; err = 2'b00;
  endtask

  task automatic do_arm(input int c);
    arm = 1'b1; count = (ADDR_W+1)'(c);
    step();
    arm = 1'b0;
  endtask

  task automatic rd_lit(input int a, input longint exp, input string nm);
    rd_en = 1'b1; rd_addr = ADDR_W'(a);
    step();
    rd_en = 1'b0;
    chk(nm, $signed(o_rd_data), exp);
  endtask

  task automatic wait_done(input int lim, input string nm);
    int k;
    k = 0;
    while (!o_done && k < lim) begin
      step();
      k++;
    end
    chk(nm, o_done, 1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; arm = 1'b0; count = '0; drv_d = 0; valid = 1'b0;
    err = 2'b00; rd_addr = '0; rd_en = 1'b0;
    idle(3);
    rst = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_wr_count", o_wr_count, 0);
    chk("rst_err", o_err_flag, 0);
    chk("rst_sat", o_sat_flag, 0);
    chk("rst_rd_data", $signed(o_rd_data), 0);

    // Basic capture of four consecutive beats and done timing.
    do_arm(4);
    chk("t1_busy", o_busy, 1);
    beat(sh(3), 2'b00);
    beat(sh(5), 2'b00);
    beat(-sh(2), 2'b00);
    beat(0, 2'b00);
    chk("t1_done_n", o_done, 0);
    step();
    chk("t1_done_n1", o_done, 0);
    chk("t1_wr_count", o_wr_count, 4);
    step();
    chk("t1_done_n2", o_done, 1);
    chk("t1_busy_n2", o_busy, 0);
    rd_lit(0, 3, "t1_rd0");
    rd_lit(1, 5, "t1_rd1");
    rd_lit(2, -2, "t1_rd2");
    rd_lit(3, 0, "t1_rd3");

    // Round half up boundaries.
    do_arm(3);
    beat(64'sd8388608, 2'b00);
    beat(64'sd8388607, 2'b00);
    beat(-64'sd8388609, 2'b00);
    wait_done(6, "t2_done");
    rd_lit(0, 1, "t2_half");
    rd_lit(1, 0, "t2_below_half");
    rd_lit(2, -1, "t2_neg");

    // Out-of-range samples.
    do_arm(2);
    beat(sh(40000), 2'b00);
    beat(-sh(40000), 2'b00);
    wait_done(6, "t3_done");
`ifdef FILTER_CAPTURE_SAT_EN
    rd_lit(0, 32767, "t3_pos");
    rd_lit(1, -32768, "t3_neg");
    chk("t3_sat_flag", o_sat_flag, 1);
`else
    rd_lit(0, -25536, "t3_pos");
    rd_lit(1, 25536, "t3_neg");
    chk("t3_sat_flag", o_sat_flag, 0);
`endif

    // Arm with a simultaneous beat, gapped beats, error beat, extra beats.
    arm = 1'b1; count = 12'd3; valid = 1'b1; drv_d = sh(9);
    step();
    arm = 1'b0; valid = 1'b0; drv_d = 0;
    beat(sh(1), 2'b00);
    idle(1);
    beat(sh(2), 2'b01);
    idle(2);
    beat(sh(3), 2'b00);
    beat(sh(7), 2'b00);
    beat(sh(8), 2'b00);
    idle(2);
    chk("t4_wr_count", o_wr_count, 3);
    chk("t4_err_flag", o_err_flag, 1);
    chk("t4_sat_cleared", o_sat_flag, 0);
    chk("t4_done", o_done, 1);
    rd_lit(0, 1, "t4_rd0");
    rd_lit(1, 2, "t4_rd1");
    rd_lit(2, 3, "t4_rd2");
    rd_lit(3, 0, "t4_rd3_untouched");

    // Reset mid-capture, then zero-length capture.
    do_arm(8);
    beat(sh(11), 2'b00);
    beat(sh(12), 2'b00);
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", o_busy, 0);
    chk("t5_done", o_done, 0);
    chk("t5_wr_count", o_wr_count, 0);
    chk("t5_err", o_err_flag, 0);
    chk("t5_rd_data", $signed(o_rd_data), 0);
    rd_lit(0, 11, "t5_keep0");
    rd_lit(1, 12, "t5_keep1");
    do_arm(0);
    chk("t5_zero_done", o_done, 1);
    chk("t5_zero_busy", o_busy, 0);
    chk("t5_zero_wr", o_wr_count, 0);

    // Count above depth is clamped to the RAM depth.
    do_arm(4095);
    for (int i = 0; i < DEPTH + 2; i++) beat(sh(i), 2'b00);
    wait_done(8, "t6_done");
    chk("t6_wr_count", o_wr_count, DEPTH);
    rd_lit(5, 5, "t6_rd5");
    rd_lit(DEPTH - 1, DEPTH - 1, "t6_rd_last");

    // Re-arm from DONE overwrites from address 0.
    do_arm(1);
    chk("t7_busy", o_busy, 1);
    chk("t7_done", o_done, 0);
    chk("t7_wr_count", o_wr_count, 0);
    beat(sh(21), 2'b00);
    wait_done(6, "t7_done_wait");
    rd_lit(0, 21, "t7_rd0");
    rd_lit(1, 1, "t7_rd1_old");

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
